// File: rtl/decode_imm_stage.sv
// IF->ID stage: classifies LA32R opcodes, generates the immediate and buffers
// decoded entries in an output register plus one skid register.

package cpu_define;
    typedef enum logic [2:0] {
        ITYPE_NONE = 3'd0,
        ITYPE_I8   = 3'd1,
        ITYPE_I12  = 3'd2,
        ITYPE_I14  = 3'd3,
        ITYPE_I16  = 3'd4,
        ITYPE_I20  = 3'd5,
        ITYPE_I21  = 3'd6,
        ITYPE_I26  = 3'd7
    } itype_e;
endpackage

module imm_gen
    import cpu_define::*;
(
    input  itype_e      itype,
    input  logic        is_unsign,
    input  logic [25:0] instr_lo,
    output logic [31:0] imm
);
    always_comb begin
        imm = '0;
        case (itype)
            ITYPE_I8:  imm = {27'b0, instr_lo[14:10]};
            ITYPE_I12: imm = is_unsign ? {20'b0, instr_lo[21:10]}
                                       : {{20{instr_lo[21]}}, instr_lo[21:10]};
            ITYPE_I14: imm = {{16{instr_lo[23]}}, instr_lo[23:10], 2'b0};
            ITYPE_I16: imm = {{14{instr_lo[25]}}, instr_lo[25:10], 2'b0};
            ITYPE_I20: imm = {instr_lo[24:5], 12'b0};
            ITYPE_I21: imm = {{11{instr_lo[4]}}, instr_lo[4:0], instr_lo[25:10]};
            ITYPE_I26: imm = {{4{instr_lo[9]}}, instr_lo[9:0], instr_lo[25:10], 2'b0};
            default:   imm = '0;
        endcase
    end
endmodule

module decode_imm_stage
    import cpu_define::*;
#(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [PC_W-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [PC_W-1:0]  out_pc,
    output itype_e           out_itype,
    output logic [31:0]      out_imm,
    output logic             out_illegal,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef struct packed {
        logic [31:0]     instr;
        logic [PC_W-1:0] pc;
        itype_e          itype;
        logic [31:0]     imm;
        logic            illegal;
    } entry_t;

    typedef enum logic [1:0] {ST_EMPTY, ST_FULL1, ST_FULL2} state_e;

    state_e      state;
    entry_t      out_q;
    entry_t      skid_q;
    entry_t      dec;
    itype_e      dec_itype;
    logic        dec_unsign;
    logic        dec_illegal;
    logic [31:0] dec_imm;
    logic        accept;
    logic        consume;

    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    // Opcode classes are checked widest-prefix first; first match wins.
    always_comb begin
        dec_itype   = ITYPE_NONE;
        dec_unsign  = 1'b0;
        dec_illegal = 1'b0;
        if (in_instr[31:15] inside {17'h00081, 17'h00089, 17'h00091}) begin
            dec_itype = ITYPE_I8;
        end else if (in_instr[31:22] inside {10'h00A, 10'h008, 10'h009, 10'h0A2, 10'h0A6}) begin
            dec_itype = ITYPE_I12;
        end else if (in_instr[31:22] inside {10'h00D, 10'h00E, 10'h00F}) begin
            dec_itype  = ITYPE_I12;
            dec_unsign = 1'b1;
        end else if (in_instr[31:24] inside {8'h20, 8'h21}) begin
            dec_itype = ITYPE_I14;
        end else if (in_instr[31:25] inside {7'h0A, 7'h0E}) begin
            dec_itype = ITYPE_I20;
        end else if (in_instr[31:26] inside {6'h10, 6'h11}) begin
            dec_itype = ITYPE_I21;
        end else if (in_instr[31:26] inside {6'h13, [6'h16:6'h1B]}) begin
            dec_itype = ITYPE_I16;
        end else if (in_instr[31:26] inside {6'h14, 6'h15}) begin
            dec_itype = ITYPE_I26;
        end else begin
            dec_illegal = 1'b1;
        end
    end

    imm_gen u_imm_gen (
        .itype     (dec_itype),
        .is_unsign (dec_unsign),
        .instr_lo  (in_instr[25:0]),
        .imm       (dec_imm)
    );

    assign dec = '{instr: in_instr, pc: in_pc, itype: dec_itype,
                   imm: dec_imm, illegal: dec_illegal};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_q     <= '0;
            skid_q    <= '0;
        end else if (flush) begin
            state     <= ST_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        out_q     <= dec;
                        out_valid <= 1'b1;
                        state     <= ST_FULL1;
                    end
                end
                ST_FULL1: begin
                    if (consume && !accept) begin
                        out_valid <= 1'b0;
                        state     <= ST_EMPTY;
                    end else if (consume && accept) begin
                        out_q <= dec;
                    end else if (accept) begin
                        skid_q   <= dec;
                        in_ready <= 1'b0;
                        state    <= ST_FULL2;
                    end
                end
                ST_FULL2: begin
                    // in_ready is low here, so only a consume can happen.
                    if (consume) begin
                        out_q    <= skid_q;
                        in_ready <= 1'b1;
                        state    <= ST_FULL1;
                    end
                end
                default: begin
                    state     <= ST_EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    // Flush deliberately leaves the counter alone; it measures back-pressure
    // seen since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign out_instr   = out_q.instr;
    assign out_pc      = out_q.pc;
    assign out_itype   = out_q.itype;
    assign out_imm     = out_q.imm;
    assign out_illegal = out_q.illegal;

endmodule
